// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding select and load-use stall scoreboard; FWD_PERF_CNT_EN enables the stall counter
module fwd_hazard_unit #(
    parameter int NUM_REGS   = 8,
    parameter int NUM_SRC    = 3,
    parameter int NUM_STAGES = 3,
    localparam int REG_W = $clog2(NUM_REGS),
    localparam int SEL_W = $clog2(NUM_STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     advance,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic                     id_wr,
    input  logic [REG_W-1:0]         id_dest,
    input  logic [1:0]               id_kind,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_used,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic [NUM_SRC*2-1:0]     fwd_kind,
    output logic [15:0]              stall_cnt
);
    logic [NUM_STAGES-1:0]            e_valid;
    logic [NUM_STAGES-1:0][REG_W-1:0] e_dest;
    logic [NUM_STAGES-1:0][1:0]       e_kind;
    logic [NUM_SRC*SEL_W-1:0]         sel_c;
    logic [NUM_SRC*2-1:0]             kind_c;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        stall  = 1'b0;
        sel_c  = '0;
        kind_c = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (id_src_used[i] && e_valid[k] && e_dest[k] == id_src[i*REG_W +: REG_W]) begin
                    sel_c[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    kind_c[i*2 +: 2]        = e_kind[k];
                end
            end
            stall = stall || (sel_c[i*SEL_W +: SEL_W] == SEL_W'(1) && kind_c[i*2 +: 2] == 2'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid  <= '0;
            e_dest   <= '0;
            e_kind   <= '0;
            fwd_sel  <= '0;
            fwd_kind <= '0;
        end else if (advance) begin
            for (int k = NUM_STAGES - 1; k > 0; k--) begin
                e_valid[k] <= e_valid[k-1] && !flush;
                e_dest[k]  <= e_dest[k-1];
                e_kind[k]  <= e_kind[k-1];
            end
            e_valid[0] <= id_valid && id_wr && !stall && !flush;
            e_dest[0]  <= id_dest;
            e_kind[0]  <= id_kind;
            fwd_sel    <= (flush || stall || !id_valid) ? '0 : sel_c;
            fwd_kind   <= (flush || stall || !id_valid) ? '0 : kind_c;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 16'h0000;
        else if (stall && advance && !flush && cnt != 16'hFFFF)
            cnt <= cnt + 16'h0001;
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = 16'h0000;
`endif
endmodule
